// File: rtl/product_multiplier.sv
// Full-width integer multiplier, L = INREG_EN+PIPEREG_EN_1..3+OUTREG_EN cycles.
// No handshake or backpressure: ce stalls every stage together, rst flushes all.

module product_multiplier_stage #(
   parameter int W  = 1,
   parameter bit EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   generate
      if (EN) begin : g_reg
         logic [W-1:0] data_q;
         logic [W-1:0] data_d;

         always_comb begin
            data_d = data_q;
            if (ce) data_d = d;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) data_q <= '0;
            else     data_q <= data_d;
         end

         assign q = data_q;
      end else begin : g_wire
         // A disabled stage is a plain wire; control inputs are intentionally ignored.
         logic unused_ctrl;
         assign unused_ctrl = clk ^ rst ^ ce;
         assign q = d;
      end
   endgenerate
endmodule

module product_multiplier #(
   parameter int ASIZE        = 16,
   parameter int BSIZE        = 16,
   parameter int A_SIGNED     = 1,
   parameter int B_SIGNED     = 1,
   parameter int INREG_EN     = 0,
   parameter int PIPEREG_EN_1 = 1,
   parameter int PIPEREG_EN_2 = 1,
   parameter int PIPEREG_EN_3 = 1,
   parameter int OUTREG_EN    = 0,
   localparam int PSIZE       = ASIZE + BSIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [ASIZE-1:0] a,
   input  logic [BSIZE-1:0] b,
   output logic [PSIZE-1:0] p
);
   logic [ASIZE-1:0]   a_in;
   logic [BSIZE-1:0]   b_in;
   logic [PSIZE-1:0]   a_ext;
   logic [PSIZE-1:0]   b_ext;
   logic [2*PSIZE-1:0] ops_s1;
   logic [PSIZE-1:0]   prod_raw;
   logic [PSIZE-1:0]   prod_s2;
   logic [PSIZE-1:0]   prod_s3;

   product_multiplier_stage #(.W(ASIZE + BSIZE), .EN(INREG_EN != 0)) u_inreg (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .d   ({a, b}),
      .q   ({a_in, b_in})
   );

   // Extending both operands to PSIZE makes a plain unsigned multiply exact in its low PSIZE bits.
   assign a_ext = (A_SIGNED != 0) ? {{BSIZE{a_in[ASIZE-1]}}, a_in} : {{BSIZE{1'b0}}, a_in};
   assign b_ext = (B_SIGNED != 0) ? {{ASIZE{b_in[BSIZE-1]}}, b_in} : {{ASIZE{1'b0}}, b_in};

   product_multiplier_stage #(.W(2 * PSIZE), .EN(PIPEREG_EN_1 != 0)) u_stage1 (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .d   ({a_ext, b_ext}),
      .q   (ops_s1)
   );

   assign prod_raw = ops_s1[2*PSIZE-1:PSIZE] * ops_s1[PSIZE-1:0];

   product_multiplier_stage #(.W(PSIZE), .EN(PIPEREG_EN_2 != 0)) u_stage2 (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .d   (prod_raw),
      .q   (prod_s2)
   );

   product_multiplier_stage #(.W(PSIZE), .EN(PIPEREG_EN_3 != 0)) u_stage3 (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .d   (prod_s2),
      .q   (prod_s3)
   );

   product_multiplier_stage #(.W(PSIZE), .EN(OUTREG_EN != 0)) u_outreg (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .d   (prod_s3),
      .q   (p)
   );
endmodule

// File: tb/tb_product_multiplier.sv
module tb_product_multiplier;
   logic        clk;
   logic        rst;
   logic        ce;
   logic [15:0] a;
   logic [15:0] b;
   logic [31:0] p;
   logic [15:0] au;
   logic [15:0] bu;
   logic [31:0] pu;

   int n_checks;
   int n_fail;

   product_multiplier dut (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .a   (a),
      .b   (b),
      .p   (p)
   );

   product_multiplier #(.A_SIGNED(0), .B_SIGNED(0)) dut_u (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .a   (au),
      .b   (bu),
      .p   (pu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] smul(input logic [15:0] x, input logic [15:0] y);
      int sx;
      int sy;
      sx = int'($signed(x));
      sy = int'($signed(y));
      return 32'(sx * sy);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      ce  = 1'b1;
      a   = 16'h1111;
      b   = 16'h2222;
      au  = 16'h0;
      bu  = 16'h0;
      #1;
      n_checks++;
      if (p !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_t0 p=%h expected=%h", p, 32'h0);
      end
      for (int i = 0; i < 20; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         tick();
         n_checks++;
         if (p !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold cycle=%0d p=%h expected=%h", i, p, 32'h0);
         end
      end
      rst = 1'b0;
      a   = 16'h0007;
      b   = 16'hFFFD;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (p !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release edge=%0d p=%h expected=%h", i + 1, p, 32'h0);
         end
      end
      tick();
      n_checks++;
      if (p !== 32'hFFFFFFEB) begin
         n_fail++;
         $display("FAIL reset_first_product p=%h expected=%h", p, 32'hFFFFFFEB);
      end
   endtask

   task automatic test_corners();
      logic [15:0] va [5];
      logic [15:0] vb [5];
      logic [31:0] ve [5];
      va = '{16'h8000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
      vb = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h1234};
      ve = '{32'h40000000, 32'hC0008000, 32'h3FFF0001, 32'h00000001, 32'h00000000};
      for (int i = 0; i < 7; i++) begin
         a = (i < 5) ? va[i] : 16'h0;
         b = (i < 5) ? vb[i] : 16'h0;
         tick();
         if (i >= 2) begin
            n_checks++;
            if (p !== ve[i-2]) begin
               n_fail++;
               $display("FAIL corner_%0d p=%h expected=%h", i - 2, p, ve[i-2]);
            end
         end
      end
   endtask

   task automatic test_stream();
      logic [31:0] hist [$];
      for (int i = 0; i < 10000; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         hist.push_back(smul(a, b));
         tick();
         if (i >= 2) begin
            n_checks++;
            if (p !== hist[i-2]) begin
               n_fail++;
               $display("FAIL stream idx=%0d p=%h expected=%h", i - 2, p, hist[i-2]);
            end
         end
      end
   endtask

   task automatic test_ce();
      // Pairs: (3,4)=12, (-2,5)=-10, (100,-100)=-10000, (9,9)=81
      a = 16'd3;    b = 16'd4;    tick();
      a = 16'hFFFE; b = 16'd5;    tick();
      a = 16'd100;  b = 16'hFF9C; tick();
      n_checks++;
      if (p !== 32'd12) begin
         n_fail++;
         $display("FAIL ce_before p=%h expected=%h", p, 32'd12);
      end
      ce = 1'b0;
      a  = 16'h5555;
      b  = 16'hAAAA;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (p !== 32'd12) begin
            n_fail++;
            $display("FAIL ce_frozen cycle=%0d p=%h expected=%h", i, p, 32'd12);
         end
      end
      ce = 1'b1;
      a  = 16'd9;
      b  = 16'd9;
      tick();
      n_checks++;
      if (p !== 32'hFFFFFFF6) begin
         n_fail++;
         $display("FAIL ce_resume0 p=%h expected=%h", p, 32'hFFFFFFF6);
      end
      a = 16'h0;
      b = 16'h0;
      tick();
      n_checks++;
      if (p !== 32'hFFFFD8F0) begin
         n_fail++;
         $display("FAIL ce_resume1 p=%h expected=%h", p, 32'hFFFFD8F0);
      end
      tick();
      n_checks++;
      if (p !== 32'd81) begin
         n_fail++;
         $display("FAIL ce_resume2 p=%h expected=%h", p, 32'd81);
      end
   endtask

   task automatic test_midstream_reset();
      a = 16'd2; b = 16'd3; tick();
      a = 16'd4; b = 16'd5; tick();
      a = 16'd6; b = 16'd7; tick();
      n_checks++;
      if (p !== 32'd6) begin
         n_fail++;
         $display("FAIL mid_full p=%h expected=%h", p, 32'd6);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (p !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_async_clear p=%h expected=%h", p, 32'h0);
      end
      #1;
      rst = 1'b0;
      a = 16'd16;
      b = 16'd16;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (p !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_flushed edge=%0d p=%h expected=%h", i + 1, p, 32'h0);
         end
      end
      tick();
      n_checks++;
      if (p !== 32'h100) begin
         n_fail++;
         $display("FAIL mid_first_product p=%h expected=%h", p, 32'h100);
      end
   endtask

   task automatic test_unsigned();
      au = 16'hFFFF;
      bu = 16'hFFFF;
      tick();
      au = 16'h8000;
      bu = 16'h0002;
      tick();
      au = 16'h0;
      bu = 16'h0;
      tick();
      n_checks++;
      if (pu !== 32'hFFFE0001) begin
         n_fail++;
         $display("FAIL unsigned_max pu=%h expected=%h", pu, 32'hFFFE0001);
      end
      tick();
      n_checks++;
      if (pu !== 32'h00010000) begin
         n_fail++;
         $display("FAIL unsigned_msb pu=%h expected=%h", pu, 32'h00010000);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_corners();
      test_stream();
      test_ce();
      test_midstream_reset();
      test_unsigned();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/product_multiplier.md
# product_multiplier

Pipelined, fully parameterised integer multiplier producing the exact full-width product of two operands, each of which can be signed or unsigned. The default build is a 16×16 signed multiplier with three register stages. It is the arithmetic core of the audio datapath and is clocked by the system `clk` with a global clock-enable `ce`.

## Interface
Parameters:
- `ASIZE`, default 16: width of operand `a`; legal range 2–72.
- `BSIZE`, default 16: width of operand `b`; legal range 2–72.
- `A_SIGNED`, default 1: 1 = `a` is two's complement; 0 = `a` is unsigned.
- `B_SIGNED`, default 1: 1 = `b` is two's complement; 0 = `b` is unsigned.
- `INREG_EN`, default 0: 1 = register the operands at the input.
- `PIPEREG_EN_1`, default 1: 1 = enable pipeline stage 1.
- `PIPEREG_EN_2`, default 1: 1 = enable pipeline stage 2.
- `PIPEREG_EN_3`, default 1: 1 = enable pipeline stage 3.
- `OUTREG_EN`, default 0: 1 = register the product at the output.
- `PSIZE`, derived as `ASIZE+BSIZE`: product width.

Ports:
- `clk`, input, 1 bit: clock; all registers update on the rising edge.
- `rst`, input, 1 bit: reset, asynchronous, active-high.
- `ce`, input, 1 bit: clock enable for every stage.
- `a`, input, `ASIZE` bits: multiplicand.
- `b`, input, `BSIZE` bits: multiplier.
- `p`, output, `PSIZE` bits: product.

## Operation
- Each operand is extended to `PSIZE` bits before multiplying:
  - sign-extended when its `*_SIGNED` parameter is 1;
  - zero-extended when its `*_SIGNED` parameter is 0.
- `p` equals the low `PSIZE` bits of the extended product. This result is exact, with no overflow, rounding or saturation.
- Mixed signedness is legal. Example: `A_SIGNED=1`, `B_SIGNED=0` treats `b` as a positive magnitude.
- Enabled stages form a chain: input reg → stage1 → stage2 → stage3 → output reg.
  - A disabled stage is a wire.
  - Stage boundaries internal to the product computation (partial products, accumulation) are an implementation choice.
  - Only the total latency is contractual.
- The same `ce` gates every stage:
  - `ce=1`: all stages advance.
  - `ce=0`: all stages hold their value and `p` is frozen.
- `rst` clears every stage register to 0 immediately, with no clock needed, and has priority over `ce`.
- With all stages disabled, the block is purely combinational and `rst`/`ce` have no effect.
- There is no handshake and no valid flag. The consumer tracks latency itself.

## Timing
- Latency L = `INREG_EN + PIPEREG_EN_1 + PIPEREG_EN_2 + PIPEREG_EN_3 + OUTREG_EN`. The default is L = 3.
- With `ce` held at 1:
  - `a` and `b` sampled at rising edge N produce their product on `p` right after edge N+L−1.
  - `p` holds that product until edge N+L.
  - Throughput is one product per clock.
- With `ce` low for k cycles, latency stretches by k; no sample is lost or duplicated.
- Reset behaviour:
  - While `rst` is high, `p` = 0.
  - After `rst` deasserts, `p` stays 0 for L−1 more edges, then shows the first post-reset operands.
  - Operands presented while `rst` is high never reach `p`.
- Reset asserted mid-stream flushes all in-flight products, and `p` goes to 0 asynchronously.
- Default boundary values (16×16 signed):
  - −32768 × −32768 = 0x40000000
  - −32768 × 32767 = 0xC0008000
  - 32767 × 32767 = 0x3FFF0001
  - −1 × −1 = 0x00000001
  - 0 × any value = 0

## Test plan
- Reset: hold `rst`=1 for 200 ns with random operands → `p`=0 throughout. After deassert, `p`=0 until the first sampled pair emerges 3 edges later.
- Corner pairs, defaults, `ce`=1: apply (0x8000,0x8000), (0x8000,0x7FFF), (0x7FFF,0x7FFF), (0xFFFF,0xFFFF), (0,0x1234) on consecutive edges → `p` = 0x40000000, 0xC0008000, 0x3FFF0001, 0x00000001, 0x00000000, each 3 edges after its input.
- Random streaming: new random `a`/`b` every edge for 100 µs → `p` at every edge matches a reference model (sign-extended product delayed 3 stages); zero mismatches.
- Clock enable: stream 3 distinct pairs, drop `ce` for 4 cycles, then raise it → `p` frozen while `ce`=0. The remaining products then appear in order with none lost.
- Mid-stream reset: pulse `rst` between edges while the pipeline is full → `p` goes to 0 immediately. Pre-reset products never appear.
- Unsigned build (`A_SIGNED=B_SIGNED=0`): 0xFFFF × 0xFFFF → `p` = 0xFFFE0001.
